toy_bus_dtcm_tgt_adapter: RTL and testbench
===========================================

// Module: toy_bus_dtcm_tgt_adapter
// PURPOSE
//   Bus target endpoint for the DTCM. Sits directly downstream of the DTCM node arbiter.
//   Takes ToyBusReq beats and turns them into accesses on a single-port synchronous SRAM
//   with 1-cycle read latency. Returns one ToyBusAck per request, in order, via a small ack FIFO.
//   The FIFO gives full 1-beat/cycle throughput and absorbs ack back-pressure.
// PARAMETERS
//   ADDR_W     14  SRAM word-index width; byte address bits [ADDR_W+1:2] are used
//   ACK_DEPTH  3   ack FIFO entries; minimum 2; 3 or more is needed for 1 beat/cycle
// PORTS
//   clk             in   1       clock; all state on rising edge
//   rst_n           in   1       asynchronous, active-low reset
//   in_req_vld      in   1       request valid (from arbiter out0)
//   in_req_rdy      out  1       request ready
//   in_req_addr     in   32      byte address
//   in_req_strb     in   4       byte write strobes (writes only)
//   in_req_data     in   32      write data
//   in_req_opcode   in   1       0 = read, 1 = write
//   in_req_src_id   in   4       requester id
//   in_req_tgt_id   in   4       target id (this DTCM)
//   out_ack_vld     out  1       ack valid (back toward arbiter ack path)
//   out_ack_rdy     in   1       ack ready
//   out_ack_opcode  out  1       echo of request opcode
//   out_ack_data    out  32      read data; 0 for writes
//   out_ack_src_id  out  4       = request tgt_id
//   out_ack_tgt_id  out  4       = request src_id
//   mem_en          out  1       SRAM access enable
//   mem_wen         out  1       SRAM write enable
//   mem_addr        out  ADDR_W  SRAM word address
//   mem_wstrb       out  4       SRAM byte write mask
//   mem_wdata       out  32      SRAM write data
//   mem_rdata       in   32      SRAM read data, valid the cycle after mem_en & !mem_wen
// BEHAVIOUR
//   - Credit rule: in_req_rdy = rst_n & ((fifo_cnt + s1_vld) < ACK_DEPTH).
//     in_req_rdy depends only on registered state; there is no comb path from out_ack_rdy.
//   - Accept = in_req_vld & in_req_rdy (cycle T).
//     In the same cycle, combinationally: mem_en=1, mem_wen=opcode, mem_addr=addr[ADDR_W+1:2],
//     mem_wstrb=strb, mem_wdata=data.
//     When not accepting: mem_en=0, mem_wen=0; other mem_* outputs are don't-care.
//   - Upper address bits (above ADDR_W+1) and addr[1:0] are ignored; addresses alias/wrap.
//   - Stage s1 registers {opcode, src_id, tgt_id} and sets s1_vld at the end of T.
//   - Cycle T+1: push {opcode, tgt_id->ack src, src_id->ack tgt, data} into the FIFO.
//     data = opcode ? 0 : mem_rdata. The push is unconditional; credits guarantee space.
//   - Cycle T+2: the entry is at the FIFO head, so out_ack_vld=1.
//     Accept-to-ack latency is 2 cycles when the FIFO is empty.
//   - Ack payload comes from the FIFO head and is held stable while out_ack_vld & !out_ack_rdy.
//     Pop on out_ack_vld & out_ack_rdy.
//   - Acks are strictly in request order.
//   - Simultaneous push and pop: fifo_cnt is unchanged. Pointers wrap modulo ACK_DEPTH.
//     ACK_DEPTH need not be a power of 2.
//   - Full: fifo_cnt + s1_vld == ACK_DEPTH, so in_req_rdy=0 and no new SRAM access starts.
//   - Empty: out_ack_vld=0. There is no FIFO bypass.
//   - Write followed by read of the same word on the next cycle returns the new data (SRAM write-first at edge).
//   - Reset (asynchronous, any time):
//       - s1_vld=0; FIFO pointers and fifo_cnt = 0.
//       - out_ack_vld=0, in_req_rdy=0, mem_en=0, mem_wen=0, ack payload=0.
//       - In-flight and queued transactions are dropped with no ack.
//       - After release, in_req_rdy=1 in the first cycle.
//   - Data-path registers may be left unreset; valid and count state must be reset.
// TESTING
//   1. Write addr 0x40, data 0x12345678, strb 0xF, src 2, tgt 5; then read 0x40.
//      -> ack{op1, data 0, src 5, tgt 2}, then ack{op0, data 0x12345678}.
//   2. Write 0x40 with 0xAABBCCDD, strb 0x3, over 0x12345678; then read.
//      -> data 0x1234CCDD.
//   3. 8 back-to-back reads with out_ack_rdy=1.
//      -> in_req_rdy stays 1; acks on 8 consecutive cycles starting 2 cycles after the first accept.
//   4. out_ack_rdy=0 while driving reads continuously.
//      -> exactly 3 accepted, then in_req_rdy=0; head payload stable.
//      Raise rdy -> the 3 acks drain in order and rdy returns.
//   5. Assert rst_n=0 mid-cycle with 2 acks queued and 1 in s1.
//      -> out_ack_vld=0 immediately; no acks after release; first new ack has fresh data.
//   6. Write 0xCAFEF00D to word 0 via addr 0x0; read addr (1<<(ADDR_W+2)).
//      -> aliases to word 0, data 0xCAFEF00D.

Source files
------------

// File: rtl/toy_bus_dtcm_tgt_adapter.sv
`default_nettype none
// ============================================================================
// toy_bus_dtcm_tgt_adapter: ToyBus target to 1-cycle SRAM, in-order acks via FIFO
// Revision: 1.0
// ============================================================================
module toy_bus_dtcm_tgt_adapter #(
   parameter int ADDR_W    = 14,
   parameter int ACK_DEPTH = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_req_vld,
   output logic              in_req_rdy,
   input  logic [31:0]       in_req_addr,
   input  logic [3:0]        in_req_strb,
   input  logic [31:0]       in_req_data,
   input  logic              in_req_opcode,
   input  logic [3:0]        in_req_src_id,
   input  logic [3:0]        in_req_tgt_id,
   output logic              out_ack_vld,
   input  logic              out_ack_rdy,
   output logic              out_ack_opcode,
   output logic [31:0]       out_ack_data,
   output logic [3:0]        out_ack_src_id,
   output logic [3:0]        out_ack_tgt_id,
   output logic              mem_en,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int PTR_W = $clog2(ACK_DEPTH);
   localparam int CNT_W = $clog2(ACK_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ACK_DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(ACK_DEPTH);

   logic              s1_vld_q, s1_vld_d;
   logic              s1_op_q, s1_op_d;
   logic [3:0]        s1_src_q, s1_src_d;
   logic [3:0]        s1_tgt_q, s1_tgt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              fifo_op_q   [ACK_DEPTH];
   logic [3:0]        fifo_src_q  [ACK_DEPTH];
   logic [3:0]        fifo_tgt_q  [ACK_DEPTH];
   logic [31:0]       fifo_data_q [ACK_DEPTH];

   logic              accept;
   logic              push;
   logic              pop;
   logic [31:0]       push_data;
   logic [CNT_W:0]    credits_used;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{in_req_addr[31:ADDR_W+2], in_req_addr[1:0]};

   always_comb begin
      // Credits cover both queued acks and the one still in s1, so the
      // unconditional push below can never overflow.
      credits_used = {1'b0, cnt_q} + {{CNT_W{1'b0}}, s1_vld_q};
      in_req_rdy   = rst_n & (credits_used < DEPTH_C);
      accept       = in_req_vld & in_req_rdy;
      push         = s1_vld_q;
      out_ack_vld  = (cnt_q != '0);
      pop          = out_ack_vld & out_ack_rdy;
      push_data    = s1_op_q ? 32'h0 : mem_rdata;

      mem_en    = accept;
      mem_wen   = accept & in_req_opcode;
      mem_addr  = in_req_addr[ADDR_W+1:2];
      mem_wstrb = in_req_strb;
      mem_wdata = in_req_data;

      s1_vld_d = accept;
      s1_op_d  = accept ? in_req_opcode : s1_op_q;
      s1_src_d = accept ? in_req_src_id : s1_src_q;
      s1_tgt_d = accept ? in_req_tgt_id : s1_tgt_q;

      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // Storage is unreset; gating with valid keeps the payload zero when empty.
      out_ack_opcode = out_ack_vld & fifo_op_q[rd_ptr_q];
      out_ack_data   = out_ack_vld ? fifo_data_q[rd_ptr_q] : 32'h0;
      out_ack_src_id = out_ack_vld ? fifo_src_q[rd_ptr_q]  : 4'h0;
      out_ack_tgt_id = out_ack_vld ? fifo_tgt_q[rd_ptr_q]  : 4'h0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_op_q  <= s1_op_d;
      s1_src_q <= s1_src_d;
      s1_tgt_q <= s1_tgt_d;
      if (push) begin
         fifo_op_q[wr_ptr_q]   <= s1_op_q;
         fifo_src_q[wr_ptr_q]  <= s1_tgt_q;
         fifo_tgt_q[wr_ptr_q]  <= s1_src_q;
         fifo_data_q[wr_ptr_q] <= push_data;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_toy_bus_dtcm_tgt_adapter.sv
`default_nettype none
// ============================================================================
// tb_toy_bus_dtcm_tgt_adapter: scoreboard bench with SRAM model and reference memory
// Revision: 1.0
// ============================================================================
module tb_toy_bus_dtcm_tgt_adapter;
   localparam int ADDR_W    = 14;
   localparam int ACK_DEPTH = 3;
   localparam int WORDS     = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_req_vld = 1'b0;
   logic              in_req_rdy;
   logic [31:0]       in_req_addr = '0;
   logic [3:0]        in_req_strb = '0;
   logic [31:0]       in_req_data = '0;
   logic              in_req_opcode = 1'b0;
   logic [3:0]        in_req_src_id = '0;
   logic [3:0]        in_req_tgt_id = '0;
   logic              out_ack_vld;
   logic              out_ack_rdy = 1'b0;
   logic              out_ack_opcode;
   logic [31:0]       out_ack_data;
   logic [3:0]        out_ack_src_id;
   logic [3:0]        out_ack_tgt_id;
   logic              mem_en;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;

   always #5 clk = ~clk;

   toy_bus_dtcm_tgt_adapter #(.ADDR_W(ADDR_W), .ACK_DEPTH(ACK_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy), .in_req_addr(in_req_addr),
      .in_req_strb(in_req_strb), .in_req_data(in_req_data), .in_req_opcode(in_req_opcode),
      .in_req_src_id(in_req_src_id), .in_req_tgt_id(in_req_tgt_id),
      .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy), .out_ack_opcode(out_ack_opcode),
      .out_ack_data(out_ack_data), .out_ack_src_id(out_ack_src_id), .out_ack_tgt_id(out_ack_tgt_id),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous SRAM, 1-cycle read latency, byte-masked writes.
   logic [31:0] sram [WORDS];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wen) begin
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   typedef struct {
      logic        op;
      logic [31:0] data;
      logic [3:0]  src;
      logic [3:0]  tgt;
      int          acc_cyc;
   } exp_t;

   logic [31:0] ref_mem [WORDS];
   exp_t        sb [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          acc_cnt = 0;
   bit          exact_lat = 1'b0;
   bit          rand_rdy  = 1'b0;
   logic [31:0] last_rd_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Request side: every accepted beat becomes one expected ack in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_req_vld && in_req_rdy) begin
            exp_t e;
            int   w;
            w = int'((in_req_addr >> 2) % WORDS);
            chk("mem_en_on_accept", 32'(mem_en), 32'd1);
            chk("mem_wen_on_accept", 32'(mem_wen), 32'(in_req_opcode));
            chk("mem_addr", 32'(mem_addr), 32'(w));
            e.op  = in_req_opcode;
            e.src = in_req_tgt_id;
            e.tgt = in_req_src_id;
            e.acc_cyc = cyc;
            if (in_req_opcode) begin
               chk("mem_wstrb", 32'(mem_wstrb), 32'(in_req_strb));
               chk("mem_wdata", mem_wdata, in_req_data);
               for (int b = 0; b < 4; b++)
                  if (in_req_strb[b]) ref_mem[w][8*b +: 8] = in_req_data[8*b +: 8];
               e.data = 32'h0;
            end else begin
               e.data = ref_mem[w];
            end
            sb.push_back(e);
            acc_cnt++;
         end else begin
            chk("mem_en_idle", 32'(mem_en), 32'd0);
            chk("mem_wen_idle", 32'(mem_wen), 32'd0);
         end
      end
   end

   // Ack side: pop and compare on each handshake; hold check under back-pressure.
   bit          hold_vld = 1'b0;
   logic [40:0] hold_pl;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld) begin
            chk("ack_vld_held", 32'(out_ack_vld), 32'd1);
            chk("ack_payload_held_lo", hold_pl[31:0],
                out_ack_data);
            chk("ack_payload_held_hi", 32'(hold_pl[40:32]),
                32'({out_ack_opcode, out_ack_src_id, out_ack_tgt_id}));
         end
         if (out_ack_vld && out_ack_rdy) begin
            chk("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_opcode", 32'(out_ack_opcode), 32'(e.op));
               chk("ack_data", out_ack_data, e.data);
               chk("ack_src_id", 32'(out_ack_src_id), 32'(e.src));
               chk("ack_tgt_id", 32'(out_ack_tgt_id), 32'(e.tgt));
               if (exact_lat) chk("ack_latency", 32'(cyc - e.acc_cyc), 32'd2);
               if (!out_ack_opcode) last_rd_data = out_ack_data;
            end
         end
         hold_vld = out_ack_vld && !out_ack_rdy;
         hold_pl  = {out_ack_opcode, out_ack_src_id, out_ack_tgt_id, out_ack_data};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ack_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   // Entered and left at 1 time unit after a rising edge; in_req_vld stays high.
   task automatic send(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data, input logic [3:0] src, input logic [3:0] tgt);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      in_req_vld = 1'b1; in_req_opcode = op; in_req_addr = addr; in_req_strb = strb;
      in_req_data = data; in_req_src_id = src; in_req_tgt_id = tgt;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_req_rdy;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      in_req_vld = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rand_rdy = 1'b0;
      out_ack_rdy = 1'b1;
      while ((sb.size() != 0 || out_ack_vld) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_done", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int a0;
      int t0;
      for (int i = 0; i < WORDS; i++) begin
         sram[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack_vld", 32'(out_ack_vld), 32'd0);
      chk("rst_req_rdy", 32'(in_req_rdy), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_wen", 32'(mem_wen), 32'd0);
      chk("rst_ack_data", out_ack_data, 32'd0);
      chk("rst_ack_ids", 32'({out_ack_opcode, out_ack_src_id, out_ack_tgt_id}), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rdy_after_release", 32'(in_req_rdy), 32'd1);
      @(posedge clk);
      #1;
      out_ack_rdy = 1'b1;

      // Write then read of one word, full and partial strobes.
      send(1'b1, 32'h40, 4'hF, 32'h12345678, 4'd2, 4'd5);
      send(1'b0, 32'h40, 4'h0, 32'h0, 4'd2, 4'd5);
      idle(); drain();
      chk("t1_read", last_rd_data, 32'h12345678);
      send(1'b1, 32'h40, 4'h3, 32'hAABBCCDD, 4'd2, 4'd5);
      send(1'b0, 32'h40, 4'h0, 32'h0, 4'd2, 4'd5);
      idle(); drain();
      chk("t2_partial", last_rd_data, 32'h1234CCDD);

      // Back-to-back reads at full throughput.
      exact_lat = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 8; i++) send(1'b0, 32'(4 * i), 4'h0, 32'h0, 4'd1, 4'd5);
      chk("t3_btb_cycles", 32'(cyc - t0), 32'd8);
      idle(); drain();
      exact_lat = 1'b0;

      // Back-pressure fills credits.
      out_ack_rdy = 1'b0;
      a0 = acc_cnt;
      in_req_vld = 1'b1; in_req_opcode = 1'b0; in_req_addr = 32'h100;
      repeat (10) @(posedge clk);
      #1;
      chk("t4_accepted", 32'(acc_cnt - a0), 32'(ACK_DEPTH));
      chk("t4_rdy_low", 32'(in_req_rdy), 32'd0);
      chk("t4_ack_vld", 32'(out_ack_vld), 32'd1);
      idle(); drain();
      chk("t4_rdy_back", 32'(in_req_rdy), 32'd1);

      // Reset with two acks queued and one in s1.
      send(1'b1, 32'h200, 4'hF, 32'h11111111, 4'd3, 4'd5);
      idle(); drain();
      out_ack_rdy = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b0, 32'h200, 4'h0, 32'h0, 4'd3, 4'd5);
      idle();
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("t5_vld_in_reset", 32'(out_ack_vld), 32'd0);
      chk("t5_rdy_in_reset", 32'(in_req_rdy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      out_ack_rdy = 1'b1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_stale_ack", 32'(out_ack_vld), 32'd0);
      send(1'b1, 32'h200, 4'hF, 32'h22222222, 4'd3, 4'd5);
      send(1'b0, 32'h200, 4'h0, 32'h0, 4'd3, 4'd5);
      idle(); drain();
      chk("t5_fresh", last_rd_data, 32'h22222222);

      // Address aliasing above the word index.
      send(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 4'd4, 4'd5);
      send(1'b0, 32'(1 << (ADDR_W + 2)), 4'h0, 32'h0, 4'd4, 4'd5);
      idle(); drain();
      chk("t6_alias", last_rd_data, 32'hCAFEF00D);

      // Randomized traffic with random ack back-pressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 31) << 2)
             | 32'($urandom_range(0, 3));
         send(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom(),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
      idle(); drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
